// File: rtl/instruction_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word requests and queues the
// returned words (with address and exception info) for IF_ID in a DEPTH-entry buffer.
module instruction_prefetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               IALIGN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] instruction_addr_if,
    output logic [XLEN-1:0] instruction_if,
    output logic            exception_if,
    output logic [3:0]      exception_cause_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Outstanding responses can reach 2*DEPTH: DEPTH being dropped plus DEPTH new ones.
    localparam int OW = PW + 2;

    logic [XLEN-1:0] r_fetch_pc;
    logic [PW-1:0]   r_head, r_tail, r_fill;
    logic [CW-1:0]   r_count;
    logic [OW-1:0]   r_pending, r_drop;
    logic            r_halted;

    logic [DEPTH-1:0][XLEN-1:0] w_slot_addr, w_slot_data;
    logic [DEPTH-1:0]           w_slot_filled, w_slot_exc, w_slot_cause;

    logic            w_misaligned, w_space, w_accept, w_resp, w_fill, w_trunc;
    logic            w_reserve, w_exc_slot, w_pop;
    logic [OW-1:0]   w_pending_next;
    logic [CW-1:0]   w_trunc_cnt, w_count_next;

    assign w_misaligned = (IALIGN == 16) ? r_fetch_pc[0] : (r_fetch_pc[1:0] != 2'b00);
    assign w_space      = r_count < CW'(DEPTH);
    assign imem_req     = rst_n && !redirect && !r_halted && w_space && !w_misaligned;
    assign imem_addr    = r_fetch_pc;
    assign w_accept     = imem_req && imem_ready;
    assign w_resp       = imem_rvalid && (r_pending != '0);
    assign w_fill       = w_resp && (r_drop == '0) && !redirect;
    // A faulting response ends the stream: later reservations are released and their responses dropped.
    assign w_trunc      = w_fill && imem_err;
    assign w_reserve    = w_accept && !w_trunc;
    assign w_exc_slot   = rst_n && !redirect && !r_halted && w_space && w_misaligned;
    assign w_pop        = if_valid && if_ready && !redirect;

    assign w_pending_next = r_pending + OW'(w_accept) - OW'(w_resp);
    assign w_trunc_cnt    = w_trunc ? CW'(r_pending - OW'(1)) : '0;
    assign w_count_next   = r_count + CW'(w_reserve || w_exc_slot) - CW'(w_pop) - w_trunc_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_drop     <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_fill     <= '0;
                r_count    <= '0;
                r_drop     <= w_pending_next;
                r_halted   <= 1'b0;
            end else begin
                if (w_accept)
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_trunc)
                    r_tail <= r_fill + PW'(1);
                else if (w_reserve || w_exc_slot)
                    r_tail <= r_tail + PW'(1);
                if (w_fill || w_exc_slot)
                    r_fill <= r_fill + PW'(1);
                if (w_pop)
                    r_head <= r_head + PW'(1);
                if (w_trunc || w_exc_slot)
                    r_halted <= 1'b1;
                if (w_trunc)
                    r_drop <= w_pending_next;
                else if (w_resp && (r_drop != '0))
                    r_drop <= r_drop - OW'(1);
                r_count <= w_count_next;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
        logic [XLEN-1:0] r_addr, r_data;
        logic            r_filled, r_exc, r_cause;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_addr   <= '0;
                r_data   <= '0;
                r_filled <= 1'b0;
                r_exc    <= 1'b0;
                r_cause  <= 1'b0;
            end else if (redirect) begin
                r_filled <= 1'b0;
            end else begin
                if ((w_reserve || w_exc_slot) && (r_tail == PW'(gi))) begin
                    r_addr   <= r_fetch_pc;
                    r_data   <= '0;
                    r_filled <= w_exc_slot;
                    r_exc    <= w_exc_slot;
                    r_cause  <= 1'b0;
                end
                if (w_fill && (r_fill == PW'(gi))) begin
                    r_data   <= imem_err ? '0 : imem_rdata;
                    r_filled <= 1'b1;
                    r_exc    <= imem_err;
                    r_cause  <= imem_err;
                end
                if (w_pop && (r_head == PW'(gi)))
                    r_filled <= 1'b0;
            end
        end

        assign w_slot_addr[gi]   = r_addr;
        assign w_slot_data[gi]   = r_data;
        assign w_slot_filled[gi] = r_filled;
        assign w_slot_exc[gi]    = r_exc;
        assign w_slot_cause[gi]  = r_cause;
    end

    assign if_valid            = w_slot_filled[r_head];
    assign instruction_addr_if = if_valid ? w_slot_addr[r_head] : '0;
    assign instruction_if      = if_valid ? w_slot_data[r_head] : '0;
    assign exception_if        = if_valid && w_slot_exc[r_head];
    assign exception_cause_if  = {3'b000, if_valid && w_slot_cause[r_head]};

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: a queue-based reference model of the prefetch
// buffer plus an in-order memory model with random latency, compared every cycle.
module tb_instruction_prefetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk, rst_n, redirect, imem_req, imem_ready, imem_rvalid, imem_err;
    logic        if_valid, if_ready, exception_if;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instruction_addr_if, instruction_if;
    logic [3:0]  exception_cause_if;

    instruction_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .IALIGN(32)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .if_valid(if_valid), .if_ready(if_ready), .instruction_addr_if(instruction_addr_if),
        .instruction_if(instruction_if), .exception_if(exception_if),
        .exception_cause_if(exception_cause_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        filled;
        logic        exc;
        logic        cause;
    } ent_t;
    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t        q[$];
    mreq_t       mq[$];
    logic [31:0] m_pc;
    int          m_pend, m_drop, cyc, last_due, lat_max;
    bit          m_halt, m_known, err_en, err_rand;
    logic [31:0] err_addr;
    int          vectors, miscompares;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: present a response, compare outputs, then advance the models on the edge.
    task automatic step();
        bit   exp_req, exp_valid, resp, accept, exc_slot, pop, trunc;
        ent_t h, e;
        int   idx;
        mreq_t m;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mdata(mq[0].addr);
            imem_err    = (err_en && mq[0].addr == err_addr) || (err_rand && $urandom_range(0, 31) == 0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
            imem_err    = 1'b0;
        end
        #1;
        exp_req   = rst_n && !redirect && !m_halt && q.size() < DEPTH && m_pc[1:0] == 2'b00;
        exp_valid = q.size() > 0 && q[0].filled;
        h = exp_valid ? q[0] : '0;
        if (m_known) begin
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(exp_valid));
            chk("instr_addr", instruction_addr_if, h.addr);
            chk("instr", instruction_if, h.data);
            chk("exc", 32'(exception_if), 32'(h.exc));
            chk("cause", 32'(exception_cause_if), 32'(h.cause));
        end
        @(posedge clk);
        if (imem_rvalid) void'(mq.pop_front());
        if (!rst_n) begin
            m_pc = RESET_PC; q.delete(); m_pend = 0; m_drop = 0; m_halt = 0; m_known = 1;
        end else begin
            resp     = imem_rvalid && m_pend > 0;
            accept   = exp_req && imem_ready;
            exc_slot = !redirect && !m_halt && q.size() < DEPTH && m_pc[1:0] != 2'b00;
            pop      = exp_valid && if_ready && !redirect;
            trunc    = 0;
            if (accept) begin
                m.addr = m_pc;
                m.due  = cyc + $urandom_range(1, lat_max);
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                mq.push_back(m);
            end
            if (resp) m_pend--;
            if (redirect) begin
                m_drop = m_pend; q.delete(); m_pc = redirect_pc; m_halt = 0;
            end else begin
                if (resp) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        idx = -1;
                        foreach (q[k]) if (idx < 0 && !q[k].filled) idx = k;
                        if (idx >= 0) begin
                            e = q[idx];
                            e.filled = 1; e.exc = imem_err; e.cause = imem_err;
                            e.data = imem_err ? 32'h0 : imem_rdata;
                            q[idx] = e;
                            if (imem_err) begin
                                m_halt = 1; trunc = 1;
                                while (q.size() > idx + 1) void'(q.pop_back());
                                m_drop = m_pend;
                            end
                        end
                    end
                end
                if (accept) begin
                    m_pend++;
                    if (trunc) m_drop++;
                    else q.push_back('{addr: m_pc, data: 32'h0, filled: 1'b0, exc: 1'b0, cause: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
                if (exc_slot) begin
                    q.push_back('{addr: m_pc, data: 32'h0, filled: 1'b1, exc: 1'b1, cause: 1'b0});
                    m_halt = 1;
                end
                if (pop) void'(q.pop_front());
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1; redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; last_due = 0; lat_max = 1;
        m_known = 0; m_halt = 0; m_pc = RESET_PC; m_pend = 0; m_drop = 0;
        err_en = 0; err_rand = 0; err_addr = 32'h0;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0; if_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
        @(negedge clk);
        repeat (3) step();
        // Back-to-back streaming with 1-cycle memory
        rst_n = 1'b1; imem_ready = 1'b1; if_ready = 1'b1;
        repeat (20) step();
        // Backpressure fills the buffer, then a single pop frees one slot
        if_ready = 1'b0; repeat (8) step();
        if_ready = 1'b1; step();
        if_ready = 1'b0; repeat (4) step();
        if_ready = 1'b1; lat_max = 3; repeat (6) step();
        // Redirect with responses in flight
        do_redirect(32'h100); repeat (15) step();
        // Misaligned target: exception entry, then idle
        do_redirect(32'h102); repeat (8) step();
        // Access fault on 0x208
        err_en = 1; err_addr = 32'h208; lat_max = 2;
        do_redirect(32'h200); repeat (12) step();
        err_en = 0;
        do_redirect(32'h300); repeat (5) step();
        // Fetch PC wraps past the top of the address space
        do_redirect(32'hFFFF_FFF8); repeat (8) step();
        // Randomised traffic
        err_rand = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            imem_ready  = $urandom_range(0, 3) != 0;
            if_ready    = $urandom_range(0, 3) != 0;
            redirect    = $urandom_range(0, 24) == 0;
            redirect_pc = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            step();
        end
        redirect = 1'b0; err_rand = 0;
        // Redirect coinciding with a response and a pop, then reset mid-stream
        imem_ready = 1'b1; if_ready = 1'b1; lat_max = 1;
        repeat (6) step();
        do_redirect(32'h400); repeat (4) step();
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 2 && mq.size() == 0) break;
        end
        rst_n = 1'b1;
        repeat (10) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
